// File: rtl/dot_prod_pkg.sv
// Shared definitions for the chunked dot-product sequencer: default sizes,
// the sequencer state type and the accumulator width helper.
package dot_prod_pkg;

  localparam int DP_N_LANES    = 8;
  localparam int DP_ELEM_W     = 8;
  localparam int DP_MAX_CHUNKS = 16;

  // IDLE   : waiting for the first chunk of a job
  // RUN    : streaming chunks of a job
  // FLUSH  : last chunk accepted, draining the pipeline into the accumulator
  // RESULT : result presented on the output handshake
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    RESULT = 2'd3
  } dp_seq_state_t;

  // Accumulator width: full product width, plus growth across the lanes,
  // plus growth across the largest non-overflowing chunk count.
  function automatic int dp_acc_w(input int n_lanes, input int elem_w,
                                  input int max_chunks);
    return 2 * elem_w + $clog2(n_lanes) + $clog2(max_chunks);
  endfunction

endpackage

// File: rtl/dot_prod_lane_array.sv
// Combinational lane array: N_LANES unsigned multipliers feeding one adder
// tree. The operand bus carries vector a in the low half, vector b in the
// high half, element i of each at [i*ELEM_W +: ELEM_W].
module dot_prod_lane_array #(
  parameter int  N_LANES = 8,
  parameter int  ELEM_W  = 8,
  localparam int PSUM_W  = 2 * ELEM_W + $clog2(N_LANES)
) (
  input  logic [2*N_LANES*ELEM_W-1:0] operands,
  output logic [PSUM_W-1:0]           psum
);

  localparam int VEC_W  = N_LANES * ELEM_W;
  localparam int PROD_W = 2 * ELEM_W;

  logic [VEC_W-1:0]  vec_a;
  logic [VEC_W-1:0]  vec_b;
  logic [PROD_W-1:0] ext_a;
  logic [PROD_W-1:0] ext_b;
  logic [PROD_W-1:0] prod;
  logic [PSUM_W-1:0] sum;

  assign vec_a = operands[VEC_W-1:0];
  assign vec_b = operands[2*VEC_W-1:VEC_W];

  // Multiply each lane at full product width and sum without truncation.
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    prod  = '0;
    sum   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      ext_a = {{ELEM_W{1'b0}}, vec_a[i*ELEM_W +: ELEM_W]};
      ext_b = {{ELEM_W{1'b0}}, vec_b[i*ELEM_W +: ELEM_W]};
      prod  = ext_a * ext_b;
      sum   = sum + {{(PSUM_W-PROD_W){1'b0}}, prod};
    end
  end

  assign psum = sum;

endmodule

// File: rtl/dot_prod_chunk_sequencer.sv
// Chunked dot-product sequencer. Chunks of N_LANES element pairs arrive on
// a valid/ready input, pass through the lane array into a registered partial
// sum (stage 1), and are added into the job accumulator (stage 2). The chunk
// flagged last closes the job; its result is offered on a valid/ready output.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready are both high. Producers hold payload stable while valid is
// high and ready is low; in_ready depends on registered state only, and the
// result fields do not change while out_valid is high and out_ready is low.
module dot_prod_chunk_sequencer
  import dot_prod_pkg::*;
#(
  parameter int  N_LANES    = DP_N_LANES,
  parameter int  ELEM_W     = DP_ELEM_W,
  parameter int  MAX_CHUNKS = DP_MAX_CHUNKS,
  localparam int PSUM_W     = 2 * ELEM_W + $clog2(N_LANES),
  localparam int ACC_W      = dp_acc_w(N_LANES, ELEM_W, MAX_CHUNKS),
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [N_LANES*ELEM_W-1:0] in_vec_a,
  input  logic [N_LANES*ELEM_W-1:0] in_vec_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_dot,
  output logic [CNT_W-1:0]          out_chunks,
  output logic                      out_ovf,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);

  dp_seq_state_t state_q;
  dp_seq_state_t state_d;

  logic              accept;
  logic              take;
  logic [PSUM_W-1:0] psum;
  logic [PSUM_W-1:0] psum_q;
  logic              p_valid_q;
  logic              p_last_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  dot_prod_lane_array #(
    .N_LANES (N_LANES),
    .ELEM_W  (ELEM_W)
  ) u_lane_array (
    .operands ({in_vec_b, in_vec_a}),
    .psum     (psum)
  );

  assign in_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept   = in_valid && in_ready;
  assign take     = (state_q == RESULT) && out_ready;

  // Stage 1: register the lane-array sum with its valid and last flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_q    <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= accept;
      p_last_q  <= accept && in_last;
      if (accept) begin
        psum_q <= psum;
      end
    end
  end

  // Stage 2: accumulate partial sums; cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (rst || take) begin
      acc_q <= '0;
    end else if (p_valid_q) begin
      acc_q <= acc_q + {{(ACC_W-PSUM_W){1'b0}}, psum_q};
    end
  end

  // Chunk count saturates at MAX_CHUNKS; one more chunk flags overflow.
  always_ff @(posedge clk) begin
    if (rst || take) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. FLUSH leaves once the last partial sum sits in stage 1,
  // so it is added to the accumulator on the same edge that enters RESULT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept && in_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (p_valid_q && p_last_q) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result fields only carry data while a result is offered.
  always_comb begin
    out_valid  = (state_q == RESULT);
    out_dot    = '0;
    out_chunks = '0;
    out_ovf    = 1'b0;
    if (state_q == RESULT) begin
      out_dot    = acc_q;
      out_chunks = cnt_q;
      out_ovf    = ovf_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/dot_prod_chunk_sequencer.md
Name: dot_prod_chunk_sequencer

Overview:
Sequencer and accumulator wrapped around an N_LANES-wide combinational dot-product lane array. It accepts a long vector pair as a stream of N_LANES-element chunks over a valid/ready handshake and feeds each chunk through the lane array. Partial sums are registered and accumulated across the chunks. When the chunk marked last arrives, one result is presented on a valid/ready output. It sits between the vector fetch front-end and the result writeback path.

Parameters:
N_LANES, 8, elements per chunk (lanes of the lane array)
ELEM_W, 8, unsigned element width in bits
MAX_CHUNKS, 16, largest chunk count per job that is guaranteed not to overflow
PSUM_W, 2*ELEM_W+$clog2(N_LANES) (19), derived localparam: lane-array sum width
ACC_W, PSUM_W+$clog2(MAX_CHUNKS) (23), derived localparam: accumulator/result width
CNT_W, $clog2(MAX_CHUNKS+1) (5), derived localparam: chunk counter width

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  chunk present
in_ready  out  1  block can accept a chunk
in_last  in  1  chunk is the final one of the job
in_vec_a  in  N_LANES*ELEM_W  packed elements, element i at [i*ELEM_W +: ELEM_W]
in_vec_b  in  N_LANES*ELEM_W  same packing as in_vec_a
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
out_dot  out  ACC_W  accumulated dot product
out_chunks  out  CNT_W  chunks accumulated, saturating at MAX_CHUNKS
out_ovf  out  1  job exceeded MAX_CHUNKS
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; acc, chunk count, ovf, stage-1 register and its valid all cleared. Outputs: in_ready=1, out_valid=0, out_dot=0, out_chunks=0, out_ovf=0, busy=0. Reset mid-job discards all in-flight data.
- Accept: a chunk is accepted when in_valid && in_ready. When in_valid=0, the inputs are don't-care.
- Stage 1 (cycle T+1 after acceptance at T): psum_q = sum over i of a_i*b_i, all unsigned, PSUM_W bits. p_valid and p_last are registered alongside psum_q.
- Stage 2 (cycle T+2): acc <= acc + zero-extended psum_q, taken modulo 2^ACC_W.
- Counting: on each accept, the count increments, saturating at MAX_CHUNKS. If a chunk is accepted while the count is already MAX_CHUNKS, ovf is set and stays set for the rest of the job.
- Throughput: 1 chunk/cycle sustained within a job.
- States:
  - IDLE: in_ready=1. Accept without last -> RUN. Accept with last -> FLUSH.
  - RUN: in_ready=1. Accept with last -> FLUSH.
  - FLUSH: in_ready=0. Waits until the last psum has been added to acc, then -> RESULT.
  - RESULT: in_ready=0, out_valid=1. out_dot=acc, out_chunks=count, out_ovf=ovf.
- Latency: last chunk accepted at cycle T -> out_valid=1 at cycle T+2.
- Output handshake: out_dot, out_chunks and out_ovf are held stable while out_valid && !out_ready.
- Result taken: on out_valid && out_ready, acc, count and ovf are cleared, state -> IDLE, and in_ready=1 in the next cycle. This gives a minimum 3-cycle gap between a job's last accept and the next job's first accept.
- Single-chunk job (in_last on the first chunk) is legal. A zero-chunk job does not exist.
- Timing: in_ready is a function of registered state only; no combinational path from in_valid or out_ready to in_ready.

Decomposition:
- Package dot_prod_pkg holds:
  - localparam defaults DP_N_LANES=8, DP_ELEM_W=8, DP_MAX_CHUNKS=16;
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH, RESULT} dp_seq_state_t;
  - function dp_acc_w(n_lanes, elem_w, max_chunks) that computes ACC_W.
- Sub-module dot_prod_lane_array (parameters N_LANES, ELEM_W): purely combinational, 2*N_LANES*ELEM_W bits in, PSUM_W bits out. It is instantiated once, and its output is registered in the sequencer.

Test Plan:
1. One chunk, all a=1, b=1, in_last=1, out_ready=1 -> out_valid exactly 2 cycles after accept; out_dot=8, out_chunks=1, out_ovf=0; in_ready=1 one cycle after the output handshake.
2. 16 back-to-back chunks, all elements 0xFF -> out_dot=16*520200=8323200, out_chunks=16, out_ovf=0; in_ready=1 on every cycle of the stream.
3. 17 chunks of all-ones -> out_dot=136, out_chunks=16 (saturated), out_ovf=1.
4. 3 chunks with a_i=i, b_i=2 and 2-cycle in_valid gaps between them -> out_dot=168, out_chunks=3; garbage on in_vec during the gaps has no effect.
5. Result pending with out_ready=0 for 5 cycles -> out_valid held at 1, out_dot constant, in_ready=0, in_valid ignored; out_ready=1 -> IDLE, and the next job's first chunk is accepted the following cycle.
6. rst asserted in FLUSH -> next cycle out_valid=0, in_ready=1, busy=0; a following 1-chunk job (a=b=3) gives out_dot=72 with no residue from the aborted job.
